// File: rtl/shared_pkg.sv
// Shared constants for the parameterised synchronous FIFO.
// Defaults, reset level, handshake levels and data extremes.
package shared_pkg;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF     = $clog2(FIFO_DEPTH_DEF);
  localparam int AF_LEVEL_DEF   = FIFO_DEPTH_DEF - 1;
  localparam int AE_LEVEL_DEF   = 1;

  localparam logic ACTIVE    = 1'b1;
  localparam logic INACTIVE  = 1'b0;
  localparam logic RST_LEVEL = 1'b0;

  localparam logic [FIFO_WIDTH_DEF-1:0] MAX_DATA  = '1;
  localparam logic [FIFO_WIDTH_DEF-1:0] ZERO_DATA = '0;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port synchronous RAM for the FIFO.
// One write port, one registered read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // write port and registered read port; read data holds without re_i
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO: pointers, count, flags, pulses.
// Storage lives in fifo_mem; data_out is zero until the first read.
module sync_fifo_param
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          flush,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          vld_q, vld_d;
  logic          wr_ok, rd_ok;
  logic [FIFO_WIDTH-1:0] rdata;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL));
  assign almostempty = (count_q <= CW'(AE_LEVEL));

  assign wr_ok = wr_en & ~full  & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  // next-state for pointers, occupancy and event pulses
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q | rd_ok;
    wr_ack_d = wr_ok;
    ovf_d    = wr_en & full  & ~flush;
    udf_d    = rd_en & empty & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_LEVEL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= INACTIVE;
      ovf_q    <= INACTIVE;
      udf_q    <= INACTIVE;
      vld_q    <= INACTIVE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // RAM read register has no reset, so mask it until a read lands
  assign data_out  = vld_q ? rdata : '0;
  assign wr_ack    = wr_ack_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign count     = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param.
// Runs with AF_LEVEL=6, AE_LEVEL=2 at depth 8, width 16.
module tb_sync_fifo_param;
  import shared_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en, rd_en, flush;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] e_dout;
  bit          w, r, wok, rok;

  sync_fifo_param #(
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .flush       (flush),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    idle();
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almostempty, 1);
    chk("rst_af", almostfull, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ack", wr_ack, 0);
    #9 rst_n = 1'b1;
    cyc();

    // fill 1..8 with threshold tracking
    for (int i = 1; i <= 8; i++) begin
      data_in = 16'(i);
      wr_en   = 1'b1;
      cyc();
      chk("fill_ack", wr_ack, 1);
      chk("fill_cnt", count, i);
      chk("fill_ae", almostempty, (i <= 2));
      chk("fill_af", almostfull, (i >= 6));
      chk("fill_full", full, (i == 8));
    end
    chk("fill_dout", data_out, 0);

    // overflow at full
    data_in = MAX_DATA;
    cyc();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_cnt", count, 8);
    idle();
    cyc();
    chk("ovf_clr", overflow, 0);

    // drain 1..8
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("drain_dout", data_out, i);
      chk("drain_cnt", count, 8 - i);
    end
    chk("drain_empty", empty, 1);

    // underflow at empty
    cyc();
    chk("udf_pulse", underflow, 1);
    chk("udf_dout", data_out, 16'h0008);
    idle();
    cyc();
    chk("udf_clr", underflow, 0);

    // simultaneous at empty: write only
    data_in = 16'h0A0A;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    cyc();
    chk("sim0_cnt", count, 1);
    chk("sim0_ack", wr_ack, 1);
    chk("sim0_udf", underflow, 1);
    chk("sim0_dout", data_out, 16'h0008);
    rd_en = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      data_in = 16'h0B00 + 16'(i);
      cyc();
    end
    chk("sim_full", full, 1);

    // simultaneous at full: read only
    data_in = 16'hDEAD;
    rd_en   = 1'b1;
    cyc();
    chk("sim8_cnt", count, 7);
    chk("sim8_ovf", overflow, 1);
    chk("sim8_ack", wr_ack, 0);
    chk("sim8_dout", data_out, 16'h0A0A);
    wr_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("rd3_dout", data_out, 16'h0B00 + i);
    end
    chk("rd3_cnt", count, 4);

    // simultaneous at 4: both accepted
    data_in = 16'hC001;
    wr_en   = 1'b1;
    cyc();
    chk("sim4_cnt", count, 4);
    chk("sim4_ack", wr_ack, 1);
    chk("sim4_ovf", overflow, 0);
    chk("sim4_dout", data_out, 16'h0B04);

    // count to 5, then flush with a write pending
    rd_en   = 1'b0;
    data_in = 16'hC002;
    cyc();
    chk("pre_flush_cnt", count, 5);
    flush   = 1'b1;
    data_in = 16'h7777;
    cyc();
    chk("flush_cnt", count, 0);
    chk("flush_ack", wr_ack, 0);
    chk("flush_empty", empty, 1);
    chk("flush_dout", data_out, 16'h0B04);
    chk("flush_ovf", overflow, 0);
    idle();

    // mixed traffic across pointer wrap
    q.delete();
    e_dout = 16'h0B04;
    for (int k = 0; k < 20; k++) begin
      w   = (k % 4) != 3;
      r   = (k >= 3) && (k % 2 == 1);
      rok = r && (q.size() > 0);
      wok = w && (q.size() < 8);
      data_in = 16'h0100 + 16'(k);
      wr_en   = w;
      rd_en   = r;
      if (rok) e_dout = q.pop_front();
      if (wok) q.push_back(data_in);
      cyc();
      chk("mix_cnt", count, q.size());
      chk("mix_dout", data_out, e_dout);
      chk("mix_ack", wr_ack, wok);
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    while (q.size() > 0) begin
      e_dout = q.pop_front();
      cyc();
      chk("wrap_dout", data_out, e_dout);
    end
    chk("wrap_empty", empty, 1);
    idle();

    // reset asserted mid-fill at count 5
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0E00 + 16'(i);
      cyc();
    end
    wr_en = 1'b0;
    chk("mid_cnt", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", data_out, 0);
    chk("arst_ack", wr_ack, 0);
    #2 rst_n = 1'b1;

    // first write after reset, then read it back
    data_in = 16'h5A5A;
    wr_en   = 1'b1;
    cyc();
    chk("post_ack", wr_ack, 1);
    chk("post_cnt", count, 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    cyc();
    chk("post_dout", data_out, 16'h5A5A);
    chk("post_empty", empty, 1);
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
